// File: rtl/mtimer_responder.sv
// mtimer_responder: memory-mapped RISC-V machine timer (mtime/mtimecmp)
// behind a single-outstanding valid/ready request/response port.
// Drives mtip when mtime >= mtimecmp.

module mtimer_responder #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mtip
);

    localparam logic [31:0] ADDR_TIME_LO = 32'h0000_8004;
    localparam logic [31:0] ADDR_TIME_HI = 32'h0000_8008;
    localparam logic [31:0] ADDR_CMP_LO  = 32'h0000_800C;
    localparam logic [31:0] ADDR_CMP_HI  = 32'h0000_8010;

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    logic [15:0] presc;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;

    logic        accept;
    logic        tick;
    logic        mapped;
    logic        wr_time_lo;
    logic        wr_time_hi;
    logic        wr_cmp_lo;
    logic        wr_cmp_hi;
    logic [31:0] load_data;

    // Handshake, increment strobe and register-map decode.
    always_comb begin
        req_ready  = !rst && (!rsp_valid || rsp_ready);
        accept     = req_valid && req_ready;
        tick       = (presc == PRESC_LAST);
        mapped     = 1'b1;
        load_data  = '0;
        case (req_addr)
            ADDR_TIME_LO: load_data = mtime[31:0];
            ADDR_TIME_HI: load_data = mtime[63:32];
            ADDR_CMP_LO:  load_data = mtimecmp[31:0];
            ADDR_CMP_HI:  load_data = mtimecmp[63:32];
            default:      mapped    = 1'b0;
        endcase
        wr_time_lo = accept && req_we && (req_addr == ADDR_TIME_LO);
        wr_time_hi = accept && req_we && (req_addr == ADDR_TIME_HI);
        wr_cmp_lo  = accept && req_we && (req_addr == ADDR_CMP_LO);
        wr_cmp_hi  = accept && req_we && (req_addr == ADDR_CMP_HI);
    end

    // Prescaler and mtime; a store to either half wins over that cycle's increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            mtime <= '0;
        end else begin
            presc <= tick ? '0 : presc + 16'd1;
            if (wr_time_lo) begin
                mtime[31:0] <= req_wdata;
            end else if (wr_time_hi) begin
                mtime[63:32] <= req_wdata;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
        end
    end

    // mtimecmp halves, written independently.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp <= '1;
        end else begin
            if (wr_cmp_lo) mtimecmp[31:0]  <= req_wdata;
            if (wr_cmp_hi) mtimecmp[63:32] <= req_wdata;
        end
    end

    // Registered level interrupt from the current-cycle comparison.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtip <= 1'b0;
        end else begin
            mtip <= (mtime >= mtimecmp);
        end
    end

    // Response register; held until consumed, dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= (!req_we && mapped) ? load_data : '0;
            rsp_err   <= !mapped;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mtimer_responder.sv
// Directed bench for mtimer_responder: one instance at PRESCALE=1 and one
// at PRESCALE=4 share all inputs; each has its own outputs.

module tb_mtimer_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        req_ready,  rsp_valid,  rsp_err,  mtip;
    logic [31:0] rsp_rdata;
    logic        req_ready4, rsp_valid4, rsp_err4, mtip4;
    logic [31:0] rsp_rdata4;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int          cyc = 0;

    logic [31:0] rd1, rd4;
    logic        er1, er4;

    always #5 clk = ~clk;

    // Count of clock edges seen with rst low since the last reset edge.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    mtimer_responder #(.PRESCALE(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mtip(mtip)
    );

    mtimer_responder #(.PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready4), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4), .mtip(mtip4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cyc(input int target);
        int guard = 0;
        while (cyc != target && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("wait_cyc", 32'(cyc), 32'(target));
    endtask

    // One request, accepted at the next edge; captures both responses.
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        chk("req_ready", 32'(req_ready), 32'd1);
        chk("req_ready4", 32'(req_ready4), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_valid4", 32'(rsp_valid4), 32'd1);
        rd1 = rsp_rdata;
        er1 = rsp_err;
        rd4 = rsp_rdata4;
        er4 = rsp_err4;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        // Reset state
        idle(3);
        req_valid = 1'b1;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_mtip", 32'(mtip), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid4", 32'(rsp_valid4), 32'd0);
        chk("rst_mtip4", 32'(mtip4), 32'd0);
        req_valid = 1'b0;
        rst = 1'b0;

        // Load mtime low in cycle 10
        wait_cyc(10);
        chk("pre_load_rsp_valid", 32'(rsp_valid), 32'd0);
        xfer(1'b0, 32'h8004, 32'h0);
        chk("load10_data", rd1, 32'd10);
        chk("load10_err", 32'(er1), 32'd0);
        chk("load10_data_p4", rd4, 32'd2);

        // Carry from bit 31 to bit 32
        xfer(1'b1, 32'h8004, 32'hFFFF_FFFF);
        chk("store_rdata_zero", rd1, 32'd0);
        chk("store_err", 32'(er1), 32'd0);
        xfer(1'b1, 32'h8008, 32'h0);
        idle(1);
        xfer(1'b0, 32'h8008, 32'h0);
        chk("carry_hi", rd1, 32'd1);
        xfer(1'b0, 32'h8004, 32'h0);
        chk("carry_lo", rd1, 32'd1);

        // 64-bit wrap
        xfer(1'b1, 32'h8008, 32'hFFFF_FFFF);
        xfer(1'b1, 32'h8004, 32'hFFFF_FFFF);
        xfer(1'b0, 32'h8008, 32'h0);
        chk("allones_hi", rd1, 32'hFFFF_FFFF);
        xfer(1'b0, 32'h8004, 32'h0);
        chk("wrap_lo", rd1, 32'd0);
        xfer(1'b0, 32'h8008, 32'h0);
        chk("wrap_hi", rd1, 32'd0);

        // mtip against mtimecmp = 100 with mtime restarted at 0
        xfer(1'b1, 32'h800C, 32'd100);
        xfer(1'b1, 32'h8010, 32'd0);
        xfer(1'b1, 32'h8008, 32'd0);
        xfer(1'b1, 32'h8004, 32'd0);
        chk("mtip_before", 32'(mtip), 32'd0);
        idle(100);
        chk("mtip_at_100", 32'(mtip), 32'd0);
        idle(1);
        chk("mtip_rise", 32'(mtip), 32'd1);
        xfer(1'b1, 32'h8010, 32'd1);
        chk("mtip_hold", 32'(mtip), 32'd1);
        idle(1);
        chk("mtip_clear", 32'(mtip), 32'd0);
        xfer(1'b1, 32'h8010, 32'd0);
        chk("mtip_low_after_lower", 32'(mtip), 32'd0);
        idle(1);
        chk("mtip_rise_after_lower", 32'(mtip), 32'd1);
        xfer(1'b1, 32'h8010, 32'd1);
        idle(1);
        chk("mtip_level_clear", 32'(mtip), 32'd0);

        // Backpressure: response held for 5 stalled cycles, then back-to-back
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h8010;
        chk("stall_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_addr = 32'h800C;
        chk("stall_first_valid", 32'(rsp_valid), 32'd1);
        chk("stall_first_data", rsp_rdata, 32'd1);
        chk("stall_ready_low", 32'(req_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_ready", 32'(req_ready), 32'd0);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_data", rsp_rdata, 32'd1);
            chk("stall_err", 32'(rsp_err), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("unstall_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("b2b_valid", 32'(rsp_valid), 32'd1);
        chk("b2b_data", rsp_rdata, 32'd100);
        idle(1);
        chk("b2b_drained", 32'(rsp_valid), 32'd0);

        // Unmapped addresses
        xfer(1'b0, 32'h8014, 32'h0);
        chk("err_load_flag", 32'(er1), 32'd1);
        chk("err_load_data", rd1, 32'd0);
        xfer(1'b1, 32'h8000, 32'hDEAD_BEEF);
        chk("err_store_flag", 32'(er1), 32'd1);
        chk("err_store_data", rd1, 32'd0);
        xfer(1'b0, 32'h8010, 32'h0);
        chk("err_cmp_hi_kept", rd1, 32'd1);
        chk("ok_err_flag", 32'(er1), 32'd0);
        xfer(1'b0, 32'h800C, 32'h0);
        chk("err_cmp_lo_kept", rd1, 32'd100);
        xfer(1'b0, 32'h8008, 32'h0);
        chk("err_time_hi_kept", rd1, 32'd0);

        // Reset while a response is pending
        xfer(1'b1, 32'h8010, 32'd0);
        idle(1);
        chk("pre_rst_mtip", 32'(mtip), 32'd1);
        rsp_ready = 1'b0;
        xfer(1'b0, 32'h800C, 32'h0);
        chk("pending_data", rd1, 32'd100);
        rst       = 1'b1;
        req_valid = 1'b1;
        #1;
        chk("rst_pending_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_drop_valid", 32'(rsp_valid), 32'd0);
        chk("rst_drop_data", rsp_rdata, 32'd0);
        chk("rst_drop_err", 32'(rsp_err), 32'd0);
        chk("rst_drop_mtip", 32'(mtip), 32'd0);
        chk("rst_drop_valid4", 32'(rsp_valid4), 32'd0);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        idle(1);
        rst = 1'b0;

        // PRESCALE=4 counting, stores at tick and non-tick cycles
        wait_cyc(3);
        xfer(1'b0, 32'h8004, 32'h0);
        chk("p4_c3", rd4, 32'd0);
        chk("p1_c3", rd1, 32'd3);
        xfer(1'b0, 32'h8004, 32'h0);
        chk("p4_c4", rd4, 32'd1);
        chk("p1_c4", rd1, 32'd4);
        chk("p4_err", 32'(er4), 32'd0);
        wait_cyc(7);
        xfer(1'b0, 32'h8004, 32'h0);
        chk("p4_c7", rd4, 32'd1);
        xfer(1'b0, 32'h8004, 32'h0);
        chk("p4_c8", rd4, 32'd2);
        wait_cyc(11);
        xfer(1'b1, 32'h8004, 32'h50);
        xfer(1'b0, 32'h8004, 32'h0);
        chk("p4_store_tick_c12", rd4, 32'h50);
        chk("p1_store_c12", rd1, 32'h50);
        xfer(1'b0, 32'h8004, 32'h0);
        chk("p4_c13", rd4, 32'h50);
        chk("p1_c13", rd1, 32'h51);
        wait_cyc(15);
        xfer(1'b0, 32'h8004, 32'h0);
        chk("p4_c15", rd4, 32'h50);
        xfer(1'b0, 32'h8004, 32'h0);
        chk("p4_c16", rd4, 32'h51);
        wait_cyc(17);
        xfer(1'b1, 32'h8004, 32'h200);
        xfer(1'b0, 32'h8004, 32'h0);
        chk("p4_c18", rd4, 32'h200);
        xfer(1'b0, 32'h8004, 32'h0);
        chk("p4_c19", rd4, 32'h200);
        xfer(1'b0, 32'h8004, 32'h0);
        chk("p4_presc_kept_c20", rd4, 32'h201);
        xfer(1'b0, 32'h8010, 32'h0);
        chk("rst_cmp_hi", rd1, 32'hFFFF_FFFF);
        chk("rst_cmp_hi4", rd4, 32'hFFFF_FFFF);
        xfer(1'b0, 32'h800C, 32'h0);
        chk("rst_cmp_lo", rd1, 32'hFFFF_FFFF);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
